// File: rtl/enigma_pkg.sv
// Shared constants, FSM state type and ASCII letter classification for the
// enigma byte-stream controller.
package enigma_pkg;

    localparam logic [7:0]  ASCII_UPPER_A = 8'h41;
    localparam logic [7:0]  ASCII_LOWER_A = 8'h61;
    localparam int unsigned ALPHA_LEN     = 26;
    localparam logic [7:0]  ERR_CHAR      = 8'h3F;
    localparam logic [7:0]  ALPHA_LAST    = 8'(ALPHA_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } enigma_state_e;

    function automatic logic is_upper(input logic [7:0] b);
        return (b >= ASCII_UPPER_A) && (b <= (ASCII_UPPER_A + ALPHA_LAST));
    endfunction

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= ASCII_LOWER_A) && (b <= (ASCII_LOWER_A + ALPHA_LAST));
    endfunction

endpackage

// File: rtl/ascii_idx_map.sv
// Combinational ASCII <-> alphabet index mapper. The forward path classifies a
// byte and strips its case base; the reverse path restores the base or flags an
// out-of-range core result.
module ascii_idx_map
    import enigma_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_letter_o,
    output logic       is_upper_o,
    output logic [7:0] idx_o,
    input  logic [7:0] res_idx_i,
    input  logic       res_upper_i,
    output logic       res_ok_o,
    output logic [7:0] res_byte_o
);

    logic fwd_upper;
    logic fwd_lower;

    assign fwd_upper   = is_upper(byte_i);
    assign fwd_lower   = is_lower(byte_i);
    assign is_letter_o = fwd_upper || fwd_lower;
    assign is_upper_o  = fwd_upper;
    assign idx_o       = byte_i - (fwd_upper ? ASCII_UPPER_A : ASCII_LOWER_A);

    assign res_ok_o    = (res_idx_i <= ALPHA_LAST);
    assign res_byte_o  = res_ok_o ? (res_idx_i + (res_upper_i ? ASCII_UPPER_A : ASCII_LOWER_A))
                                  : ERR_CHAR;

endmodule

// File: rtl/enigma_io_ctrl.sv
// Byte-stream front/back end for the enigma core: one byte in flight, letters
// go through the core, everything else bypasses it in order.
//
//   state    | meaning
//   ST_IDLE  | ready for an input byte
//   ST_ISSUE | one-cycle core strobe with the letter index
//   ST_WAIT  | waiting for core_done, timeout down-counter running
//   ST_OUT   | output byte presented until m_ready
module enigma_io_ctrl
    import enigma_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             core_valid,
    output logic [7:0]       core_din,
    input  logic             core_done,
    input  logic [7:0]       core_dout,
    output logic [CNT_W-1:0] letter_cnt,
    output logic             err_timeout,
    output logic             err_range
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    enigma_state_e    state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             upper_q, upper_d;
    logic [7:0]       din_q, din_d;
    logic [7:0]       mdata_q, mdata_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_t_q, err_t_d;
    logic             err_r_q, err_r_d;
    logic             s_ready_q;

    logic             map_is_letter;
    logic             map_is_upper;
    logic [7:0]       map_idx;
    logic             map_res_ok;
    logic [7:0]       map_res_byte;

    ascii_idx_map u_map (
        .byte_i      (s_data),
        .is_letter_o (map_is_letter),
        .is_upper_o  (map_is_upper),
        .idx_o       (map_idx),
        .res_idx_i   (core_dout),
        .res_upper_i (upper_q),
        .res_ok_o    (map_res_ok),
        .res_byte_o  (map_res_byte)
    );

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        upper_d = upper_q;
        din_d   = din_q;
        mdata_d = mdata_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        err_t_d = err_t_q;
        err_r_d = err_r_q;

        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    byte_d  = s_data;
                    upper_d = map_is_upper;
                    if (map_is_letter) begin
                        din_d   = map_idx;
                        state_d = ST_ISSUE;
                    end else begin
                        mdata_d = s_data;
                        state_d = ST_OUT;
                    end
                end
            end
            ST_ISSUE: begin
                tmo_d   = TMO_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done is tested first so it wins over the terminal count
                if (core_done) begin
                    mdata_d = map_res_byte;
                    if (!map_res_ok) begin
                        err_r_d = 1'b1;
                    end
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_OUT;
                end else if (tmo_q == '0) begin
                    mdata_d = byte_q;
                    err_t_d = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (set) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_t_d = 1'b0;
            err_r_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            byte_q    <= '0;
            upper_q   <= 1'b0;
            din_q     <= '0;
            mdata_q   <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            err_t_q   <= 1'b0;
            err_r_q   <= 1'b0;
            s_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            upper_q   <= upper_d;
            din_q     <= din_d;
            mdata_q   <= mdata_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            err_t_q   <= err_t_d;
            err_r_q   <= err_r_d;
            s_ready_q <= (state_d == ST_IDLE);
        end
    end

    assign s_ready     = s_ready_q;
    assign m_valid     = (state_q == ST_OUT);
    assign m_data      = mdata_q;
    assign core_valid  = (state_q == ST_ISSUE);
    assign core_din    = din_q;
    assign letter_cnt  = cnt_q;
    assign err_timeout = err_t_q;
    assign err_range   = err_r_q;

endmodule

// File: tb/tb_enigma_io_ctrl.sv
// Scoreboard bench for enigma_io_ctrl: directed scenarios followed by random
// traffic against a core model with random latency and results.
module tb_enigma_io_ctrl;

    localparam int TMO = 64;

    typedef struct { int idx; int val; int lat; } plan_t;
    typedef struct { int data; int lat; int cnt; int et; int er; } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        set = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        core_valid;
    logic [7:0]  core_din;
    logic        core_done;
    logic [7:0]  core_dout;
    logic [15:0] letter_cnt;
    logic        err_timeout;
    logic        err_range;

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    rdy_mode = 0;
    bit    resp_busy = 1'b0;
    bit    have_cur = 1'b0;
    int    cnt_m = 0;
    int    et_m = 0;
    int    er_m = 0;
    exp_t  cur;
    plan_t rp;
    int    cur_hs;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    hs_q[$];

    enigma_io_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .set         (set),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .core_valid  (core_valid),
        .core_din    (core_din),
        .core_done   (core_done),
        .core_dout   (core_dout),
        .letter_cnt  (letter_cnt),
        .err_timeout (err_timeout),
        .err_range   (err_range)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Core model: answers each strobe according to the plan pushed by the stimulus.
    initial begin
        core_done = 1'b0;
        core_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (core_valid) begin
                resp_busy = 1'b1;
                if (plan_q.size() == 0) begin
                    fail_now("unexpected core_valid");
                end else begin
                    rp = plan_q.pop_front();
                    chk("core_din", 32'(core_din), 32'(rp.idx));
                    @(negedge clk);
                    chk("core_valid one cycle", 32'(core_valid), 32'd0);
                    if (rp.lat > 0) begin
                        repeat (rp.lat - 1) @(posedge clk);
                        #1;
                        core_done = 1'b1;
                        core_dout = 8'(rp.val);
                        @(posedge clk);
                        #1;
                        core_done = 1'b0;
                        core_dout = 8'($urandom_range(0, 255));
                    end
                end
                resp_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the expected entry at the first cycle of each output byte.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0 || hs_q.size() == 0) begin
                        fail_now("unexpected output byte");
                        cur.data = int'(m_data);
                    end else begin
                        cur    = exp_q.pop_front();
                        cur_hs = hs_q.pop_front();
                        chk("m_data", 32'(m_data), 32'(cur.data));
                        chk("out latency", 32'(cyc - cur_hs + 1), 32'(cur.lat));
                        chk("letter_cnt", 32'(letter_cnt), 32'(cur.cnt));
                        chk("err_timeout", 32'(err_timeout), 32'(cur.et));
                        chk("err_range", 32'(err_range), 32'(cur.er));
                    end
                    have_cur = 1'b1;
                end else begin
                    chk("m_data held", 32'(m_data), 32'(cur.data));
                end
                chk("s_ready low in OUT", 32'(s_ready), 32'd0);
                if (m_ready) have_cur = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit track);
        int n;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            fail_now("s_ready timeout");
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom_range(0, 255));
        if (track) hs_q.push_back(cyc);
    endtask

    // Reference model: expected output from the byte, the planned core result and latency.
    task automatic issue(input int b, input int val, input int lat);
        exp_t  e;
        plan_t p;
        bit    up, lo;
        up = (b >= 65 && b <= 90);
        lo = (b >= 97 && b <= 122);
        if (up || lo) begin
            p.idx = up ? b - 65 : b - 97;
            p.val = val;
            p.lat = lat;
            plan_q.push_back(p);
            if (lat == 0 || lat > TMO) begin
                e.data = b;
                e.lat  = TMO + 2;
                et_m   = 1;
            end else begin
                e.lat = lat + 2;
                cnt_m = (cnt_m + 1) % 65536;
                if (val < 26) begin
                    e.data = (up ? 65 : 97) + val;
                end else begin
                    e.data = 63;
                    er_m   = 1;
                end
            end
        end else begin
            e.data = b;
            e.lat  = 1;
        end
        e.cnt = cnt_m;
        e.et  = et_m;
        e.er  = er_m;
        exp_q.push_back(e);
        send(8'(b), 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || have_cur || resp_busy || m_valid) && n < 1000);
        if (n >= 1000) fail_now("wait_idle timeout");
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, val, lat, n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst s_ready", 32'(s_ready), 32'd1);
        chk("rst m_valid", 32'(m_valid), 32'd0);
        chk("rst m_data", 32'(m_data), 32'd0);
        chk("rst core_valid", 32'(core_valid), 32'd0);
        chk("rst core_din", 32'(core_din), 32'd0);
        chk("rst letter_cnt", 32'(letter_cnt), 32'd0);
        chk("rst errors", {30'd0, err_timeout, err_range}, 32'd0);
        reset_n = 1'b1;

        issue(8'h41, 3, 5);
        wait_idle();
        issue(8'h7A, 0, 2);
        wait_idle();
        issue(8'h20, 0, 0);
        wait_idle();
        chk("cnt after space", 32'(letter_cnt), 32'd2);
        issue(8'h62, 7, TMO);
        wait_idle();
        issue(8'h51, 4, 70);
        wait_idle();
        chk("cnt after late done", 32'(letter_cnt), 32'(cnt_m));
        chk("sticky timeout", 32'(err_timeout), 32'd1);
        issue(8'h6D, 30, 3);
        wait_idle();

        @(negedge clk);
        rdy_mode = 2;
        issue(8'h20, 0, 0);
        repeat (11) @(negedge clk);
        chk("stall m_valid", 32'(m_valid), 32'd1);
        chk("stall m_data", 32'(m_data), 32'h20);
        rdy_mode = 0;
        wait_idle();

        begin
            plan_t p;
            p.idx = 10;
            p.val = 5;
            p.lat = 8;
            plan_q.push_back(p);
        end
        send(8'h6B, 1'b0);
        n = 0;
        while (!core_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!core_valid) fail_now("abort core_valid missing");
        repeat (3) @(posedge clk);
        #1;
        set = 1'b1;
        @(posedge clk);
        #1;
        set = 1'b0;
        cnt_m = 0;
        et_m  = 0;
        er_m  = 0;
        @(negedge clk);
        chk("set s_ready", 32'(s_ready), 32'd1);
        chk("set m_valid", 32'(m_valid), 32'd0);
        chk("set letter_cnt", 32'(letter_cnt), 32'd0);
        chk("set errors", {30'd0, err_timeout, err_range}, 32'd0);
        wait_idle();
        chk("done after set ignored", 32'(letter_cnt), 32'd0);

        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = 65 + $urandom_range(0, 25);
                4, 5, 6:    b = 97 + $urandom_range(0, 25);
                default: begin
                    do b = $urandom_range(0, 255);
                    while ((b >= 65 && b <= 90) || (b >= 97 && b <= 122));
                end
            endcase
            val = ($urandom_range(0, 19) < 3) ? $urandom_range(26, 255) : $urandom_range(0, 25);
            case ($urandom_range(0, 19))
                0:       lat = 0;
                1:       lat = TMO;
                default: lat = $urandom_range(1, 12);
            endcase
            issue(b, val, lat);
        end
        wait_idle();
        rdy_mode = 0;
        chk("final letter_cnt", 32'(letter_cnt), 32'(cnt_m));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
